// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared types for the RAM port arbiter
package k_and_s_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {PORT_CORE, PORT_DBG} arb_port_t;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational two-way round-robin winner selection with debug lock
module ram_arb_pick
  import k_and_s_pkg::*;
(
  input  logic      core_req_i,
  input  logic      dbg_req_i,
  input  logic      dbg_lock_i,
  input  arb_port_t last_grant_i,
  output logic      valid_o,
  output arb_port_t winner_o
);

  always_comb begin
    valid_o  = core_req_i | dbg_req_i;
    winner_o = PORT_CORE;
    if (dbg_req_i && !core_req_i) begin
      winner_o = PORT_DBG;
    end else if (dbg_req_i && core_req_i) begin
      // A locked debug port keeps winning ties once it holds the last grant.
      if (last_grant_i == PORT_CORE || dbg_lock_i) begin
        winner_o = PORT_DBG;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one synchronous-read RAM between core and debug ports
module ram_port_arbiter
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] rdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  arb_port_t         last_q, last_d;
  arb_port_t         owner_q, owner_d;
  logic              wr_q, wr_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick_valid;
  arb_port_t         pick_winner;

  ram_arb_pick u_pick (
    .core_req_i   (core_req),
    .dbg_req_i    (dbg_req),
    .dbg_lock_i   (dbg_lock),
    .last_grant_i (last_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= PORT_DBG;
      owner_q <= PORT_CORE;
      wr_q    <= 1'b0;
      first_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    first_d = 1'b0;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(ACC_CYCLES - 1);
          last_d  = pick_winner;
          owner_d = pick_winner;
          first_d = 1'b1;
          if (pick_winner == PORT_DBG) begin
            wr_d    = dbg_we;
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end else begin
            wr_d    = core_we;
            we_d    = core_we;
            addr_d  = core_addr;
            wdata_d = core_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!wr_q) begin
            rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign core_gnt   = first_q && (owner_q == PORT_CORE);
  assign dbg_gnt    = first_q && (owner_q == PORT_DBG);
  assign core_done  = (state_q == DONE) && (owner_q == PORT_CORE);
  assign dbg_done   = (state_q == DONE) && (owner_q == PORT_DBG);
  assign core_stall = core_req & ~core_done;
  assign rdata      = rdata_q;
  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_wdata  = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [4:0]  core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic        core_gnt, core_done;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_done;
  logic [15:0] rdata;
  logic        core_stall;
  logic [4:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] mem [32];

  logic        b_dbg_req = 1'b0;
  logic        b_core_gnt, b_core_done, b_dbg_gnt, b_dbg_done, b_core_stall, b_ram_we;
  logic [15:0] b_rdata, b_ram_wdata;
  logic [4:0]  b_ram_addr;
  logic [15:0] b_ram_rdata = 16'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(16), .ACC_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_done(core_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
    .rdata(rdata), .core_stall(core_stall),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_port_arbiter #(.ADDR_W(5), .DATA_W(16), .ACC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .core_req(1'b0), .core_we(1'b0), .core_addr(5'h0), .core_wdata(16'h0),
    .core_gnt(b_core_gnt), .core_done(b_core_done),
    .dbg_req(b_dbg_req), .dbg_we(1'b0), .dbg_addr(5'h2), .dbg_wdata(16'h0),
    .dbg_lock(1'b0), .dbg_gnt(b_dbg_gnt), .dbg_done(b_dbg_done),
    .rdata(b_rdata), .core_stall(b_core_stall),
    .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  always @(posedge clk) begin
    if (rst) mem[3] <= 16'hBEEF;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    next_cycle();
    next_cycle();
    #1;
    check("rst_core_gnt", {31'b0, core_gnt}, 0);
    check("rst_dbg_gnt", {31'b0, dbg_gnt}, 0);
    check("rst_core_done", {31'b0, core_done}, 0);
    check("rst_dbg_done", {31'b0, dbg_done}, 0);
    check("rst_rdata", {16'b0, rdata}, 0);
    check("rst_ram_addr", {27'b0, ram_addr}, 0);
    check("rst_ram_we", {31'b0, ram_we}, 0);
    check("rst_ram_wdata", {16'b0, ram_wdata}, 0);
    check("rst_core_stall", {31'b0, core_stall}, 0);
    next_cycle();
    rst = 1'b0;

    // core-only read of address 3
    next_cycle();
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'd3;
    #1;
    check("rd_c0_stall", {31'b0, core_stall}, 1);
    check("rd_c0_gnt", {31'b0, core_gnt}, 0);
    next_cycle(); #1;
    check("rd_c1_gnt", {31'b0, core_gnt}, 1);
    check("rd_c1_addr", {27'b0, ram_addr}, 3);
    check("rd_c1_stall", {31'b0, core_stall}, 1);
    next_cycle(); #1;
    check("rd_c2_gnt", {31'b0, core_gnt}, 0);
    check("rd_c2_addr", {27'b0, ram_addr}, 3);
    check("rd_c2_stall", {31'b0, core_stall}, 1);
    check("rd_c2_done", {31'b0, core_done}, 0);
    next_cycle(); #1;
    check("rd_c3_done", {31'b0, core_done}, 1);
    check("rd_c3_rdata", {16'b0, rdata}, 32'hBEEF);
    check("rd_c3_stall", {31'b0, core_stall}, 0);
    core_req = 1'b0;

    // round-robin from reset
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    next_cycle();
    core_req = 1'b1; dbg_req = 1'b1; core_addr = 5'd3; dbg_addr = 5'd3;
    for (int i = 1; i <= 15; i++) begin
      next_cycle(); #1;
      check($sformatf("rr_core_gnt_%0d", i), {31'b0, core_gnt}, (i == 1 || i == 9) ? 1 : 0);
      check($sformatf("rr_dbg_gnt_%0d", i), {31'b0, dbg_gnt}, (i == 5 || i == 13) ? 1 : 0);
    end

    // debug lock after a debug grant
    next_cycle();
    dbg_lock = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      next_cycle();
      if (i == 10) dbg_lock = 1'b0;
      #1;
      check($sformatf("lk_dbg_gnt_%0d", i), {31'b0, dbg_gnt}, (i == 1 || i == 5 || i == 9) ? 1 : 0);
      check($sformatf("lk_core_gnt_%0d", i), {31'b0, core_gnt}, (i == 13) ? 1 : 0);
    end
    next_cycle();
    core_req = 1'b0; dbg_req = 1'b0;
    next_cycle();

    // debug write then core read of 5'h1F
    next_cycle();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'h1F; dbg_wdata = 16'h1234;
    next_cycle(); #1;
    check("wr_gnt", {31'b0, dbg_gnt}, 1);
    check("wr_ram_we1", {31'b0, ram_we}, 1);
    check("wr_ram_wdata", {16'b0, ram_wdata}, 32'h1234);
    check("wr_ram_addr", {27'b0, ram_addr}, 32'h1F);
    next_cycle(); #1;
    check("wr_ram_we2", {31'b0, ram_we}, 0);
    next_cycle();
    dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    check("wr_done", {31'b0, dbg_done}, 1);
    check("wr_ram_we3", {31'b0, ram_we}, 0);
    check("wr_rdata_kept", {16'b0, rdata}, 32'hBEEF);
    next_cycle();
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'h1F;
    next_cycle();
    next_cycle();
    next_cycle(); #1;
    check("rb_done", {31'b0, core_done}, 1);
    check("rb_rdata", {16'b0, rdata}, 32'h1234);
    core_req = 1'b0;

    // reset in the second ACCESS cycle of a core read
    next_cycle();
    core_req = 1'b1; core_addr = 5'd3;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; core_req = 1'b0;
    #1;
    check("ab_core_gnt", {31'b0, core_gnt}, 0);
    check("ab_core_done", {31'b0, core_done}, 0);
    check("ab_rdata", {16'b0, rdata}, 0);
    check("ab_ram_addr", {27'b0, ram_addr}, 0);
    check("ab_ram_we", {31'b0, ram_we}, 0);
    check("ab_ram_wdata", {16'b0, ram_wdata}, 0);
    check("ab_core_stall", {31'b0, core_stall}, 0);
    next_cycle(); #1;
    check("ab_no_done", {31'b0, core_done}, 0);
    core_req = 1'b1; dbg_req = 1'b1;
    next_cycle(); #1;
    check("ab_tie_core", {31'b0, core_gnt}, 1);
    check("ab_tie_dbg", {31'b0, dbg_gnt}, 0);
    core_req = 1'b0; dbg_req = 1'b0;
    next_cycle();
    next_cycle();

    // ACC_CYCLES=1 debug read and back-to-back request
    next_cycle();
    b_dbg_req = 1'b1;
    next_cycle(); #1;
    check("a1_gnt1", {31'b0, b_dbg_gnt}, 1);
    check("a1_done1", {31'b0, b_dbg_done}, 0);
    next_cycle(); #1;
    check("a1_done2", {31'b0, b_dbg_done}, 1);
    check("a1_gnt2", {31'b0, b_dbg_gnt}, 0);
    next_cycle(); #1;
    check("a1_gnt3", {31'b0, b_dbg_gnt}, 0);
    next_cycle(); #1;
    check("a1_gnt4", {31'b0, b_dbg_gnt}, 1);
    b_dbg_req = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
